pipe_ctrl: RTL and testbench

Central sequencing controller for the five-stage pipeline (IF/ID/EX/MEM/WB).
- Holds a small scoreboard of in-flight destination registers, detects load-use hazards and produces registered forwarding selects for the EX stage.
- Generates stall, flush and enable signals for the PC and pipeline registers.
- Runs the halt-drain state machine that stops fetch on HALT and asserts halted once the pipeline is empty.
- Sits beside the decoder and consumes its RegWrite/MemToReg/halt outputs for the instruction in ID.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_scoreboard.sv | 50 +++++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// PIPE_REG_AW is also used by the decoder, so both sides agree on register address width.
package pipe_pkg;

   localparam int PIPE_REG_AW = 3;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   typedef struct packed {
      logic                   valid;
      logic [PIPE_REG_AW-1:0] rd;
      logic                   load;
   } sb_entry_t;

   // The EX entry is checked first because it holds the younger result.
   function automatic logic [1:0] fwd_sel(
      input logic                   used,
      input logic [PIPE_REG_AW-1:0] src,
      input sb_entry_t              ex,
      input sb_entry_t              mem
   );
      if (used && ex.valid && (ex.rd == src))
         return FWD_EXMEM;
      if (used && mem.valid && (mem.rd == src))
         return FWD_MEMWB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath/decoder and the sequencing controller.
// The datapath side uses master; the controller uses slave.
interface pipe_ctrl_if #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic              id_regwrite;
   logic              id_memtoreg;
   logic              id_halt;
   logic [REG_AW-1:0] id_rd;
   logic [REG_AW-1:0] id_rs;
   logic              id_rs_used;
   logic [REG_AW-1:0] id_rt;
   logic              id_rt_used;
   logic              ex_br_taken;
   logic              mem_busy;

   logic              pc_en;
   logic              ifid_en;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              exmem_en;
   logic              memwb_en;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_regwrite, id_memtoreg, id_halt, id_rd, id_rs, id_rs_used,
             id_rt, id_rt_used, ex_br_taken, mem_busy,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
             fwd_a, fwd_b, halted, stall_cnt
   );

   modport slave (
      input  id_valid, id_regwrite, id_memtoreg, id_halt, id_rd, id_rs, id_rs_used,
             id_rt, id_rt_used, ex_br_taken, mem_busy,
      output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
             fwd_a, fwd_b, halted, stall_cnt
   );
endinterface

// File: rtl/pipe_scoreboard.sv
// Three-entry in-flight destination scoreboard (EX, MEM, WB) with load-use detection
// and registered forwarding selects for the instruction entering EX.
module pipe_scoreboard
   import pipe_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   shift_en,
   input  logic                   ex_wr,
   input  logic                   fwd_clr,
   input  logic                   id_valid,
   input  logic                   id_memtoreg,
   input  logic [PIPE_REG_AW-1:0] id_rd,
   input  logic [PIPE_REG_AW-1:0] id_rs,
   input  logic                   id_rs_used,
   input  logic [PIPE_REG_AW-1:0] id_rt,
   input  logic                   id_rt_used,
   output logic                   load_use,
   output logic                   sb_empty,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b
);

   sb_entry_t ex_q;
   sb_entry_t mem_q;
   sb_entry_t wb_q;

   assign load_use = id_valid && ex_q.valid && ex_q.load &&
                     ((id_rs_used && (ex_q.rd == id_rs)) ||
                      (id_rt_used && (ex_q.rd == id_rt)));

   assign sb_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else if (shift_en) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= '{valid: ex_wr, rd: id_rd, load: (id_memtoreg && ex_wr)};
         fwd_a <= fwd_clr ? FWD_RF : fwd_sel(id_rs_used, id_rs, ex_q, mem_q);
         fwd_b <= fwd_clr ? FWD_RF : fwd_sel(id_rt_used, id_rt, ex_q, mem_q);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stall/flush/enable generation, halt drain and stall counter.
//   state     | meaning
//   ST_RUN    | normal issue; hazards, flushes and freezes handled each cycle
//   ST_DRAIN  | HALT issued; fetch stopped, older instructions and HALT retire
//   ST_HALTED | pipeline empty; everything held until reset
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   pipe_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [1:0]       drain_cnt;
   logic [CNT_W-1:0] stall_cnt;

   logic [REG_AW-1:0] id_rd;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic freeze, run, flush, stall, go_drain, drain_done;
   logic load_use, sb_empty, shift_en, ex_wr, bubble;
   logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en;

   assign id_rd = bus.id_rd;
   assign id_rs = bus.id_rs;
   assign id_rt = bus.id_rt;

   assign freeze     = bus.mem_busy;
   assign run        = (state == ST_RUN);
   assign flush      = run && !freeze && bus.ex_br_taken;
   assign stall      = run && !freeze && !bus.ex_br_taken && load_use;
   assign go_drain   = run && !freeze && !bus.ex_br_taken && !load_use &&
                       bus.id_valid && bus.id_halt;
   // Counter at zero means HALT has taken three non-frozen steps and left WB.
   assign drain_done = (state == ST_DRAIN) && (drain_cnt == 2'd0) && sb_empty && !freeze;

   assign shift_en = !freeze && (state != ST_HALTED);
   assign bubble   = !run || flush || stall;
   assign ex_wr    = !bubble && bus.id_valid && bus.id_regwrite && !bus.id_halt;

   pipe_scoreboard u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_en    (shift_en),
      .ex_wr       (ex_wr),
      .fwd_clr     (bubble || !bus.id_valid),
      .id_valid    (bus.id_valid),
      .id_memtoreg (bus.id_memtoreg),
      .id_rd       (id_rd),
      .id_rs       (id_rs),
      .id_rs_used  (bus.id_rs_used),
      .id_rt       (id_rt),
      .id_rt_used  (bus.id_rt_used),
      .load_use    (load_use),
      .sb_empty    (sb_empty),
      .fwd_a       (bus.fwd_a),
      .fwd_b       (bus.fwd_b)
   );

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      if (rst_n) begin
         if ((state == ST_HALTED) || freeze) begin
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
         end else if (state == ST_DRAIN) begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end else if (flush) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end else if (stall) begin
            ifid_flush = 1'b0;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         drain_cnt <= 2'd0;
         stall_cnt <= '0;
      end else begin
         if ((stall || freeze) && (state != ST_HALTED) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         case (state)
            ST_RUN: begin
               if (go_drain) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= 2'd3;
               end
            end
            ST_DRAIN: begin
               if (!freeze && (drain_cnt != 2'd0))
                  drain_cnt <= drain_cnt - 2'd1;
               if (drain_done)
                  state <= ST_HALTED;
            end
            default: state <= ST_HALTED;
         endcase
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.exmem_en    = exmem_en;
   assign bus.memwb_en    = memwb_en;
   assign bus.halted      = (state == ST_HALTED);
   assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load-use, freeze, flush, halt drain and reset.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.REG_AW(3), .CNT_W(16)) bus ();

   pipe_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic drive(input logic v, input logic rw, input logic mr, input logic h,
                        input logic [2:0] rd, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu);
      bus.id_valid    = v;
      bus.id_regwrite = rw;
      bus.id_memtoreg = mr;
      bus.id_halt     = h;
      bus.id_rd       = rd;
      bus.id_rs       = rs;
      bus.id_rs_used  = rsu;
      bus.id_rt       = rt;
      bus.id_rt_used  = rtu;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      bus.ex_br_taken = 1'b0;
      bus.mem_busy    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #2;
      n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL reset_pc_en got %b exp 0", bus.pc_en); end
      n_cmp++; if ({bus.ifid_en, bus.exmem_en, bus.memwb_en} !== 3'b000) begin n_err++; $display("FAIL reset_en got %b exp 000", {bus.ifid_en, bus.exmem_en, bus.memwb_en}); end
      n_cmp++; if ({bus.ifid_flush, bus.idex_bubble} !== 2'b11) begin n_err++; $display("FAIL reset_flush got %b exp 11", {bus.ifid_flush, bus.idex_bubble}); end
      n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd got %b exp 0000", {bus.fwd_a, bus.fwd_b}); end
      n_cmp++; if (bus.halted !== 1'b0 || bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_halt_cnt got %b/%0d exp 0/0", bus.halted, bus.stall_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble} !== 4'b1100) begin n_err++; $display("FAIL reset_release got %b exp 1100", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble}); end
      tick();
   endtask

   task automatic test_fwd_exmem();
      do_reset();
      drive(1, 1, 0, 0, 3'd1, 3'd2, 1, 3'd3, 1);   // ADD R1,R2,R3
      tick();
      drive(1, 1, 0, 0, 3'd2, 3'd1, 1, 3'd3, 1);   // ADD R2,R1,R3
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.idex_bubble} !== 2'b10) begin n_err++; $display("FAIL fwd_nostall got %b exp 10", {bus.pc_en, bus.idex_bubble}); end
      tick();
      idle();
      @(negedge clk);
      n_cmp++; if (bus.fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_exmem_a got %b exp 01", bus.fwd_a); end
      n_cmp++; if (bus.fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_exmem_b got %b exp 00", bus.fwd_b); end
      n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL fwd_stall_cnt got %0d exp 0", bus.stall_cnt); end
      tick();
      @(negedge clk);
      n_cmp++; if (bus.fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_bubble_clear got %b exp 00", bus.fwd_a); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 1, 1, 0, 3'd1, 3'd4, 1, 3'd0, 0);   // LD R1,(R4)
      tick();
      drive(1, 1, 0, 0, 3'd2, 3'd1, 1, 3'd1, 1);   // ADD R2,R1,R1
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.idex_bubble, bus.exmem_en, bus.memwb_en} !== 5'b00111) begin n_err++; $display("FAIL lu_stall got %b exp 00111", {bus.pc_en, bus.ifid_en, bus.idex_bubble, bus.exmem_en, bus.memwb_en}); end
      tick();
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.idex_bubble} !== 2'b10) begin n_err++; $display("FAIL lu_one_stall got %b exp 10", {bus.pc_en, bus.idex_bubble}); end
      tick();
      idle();
      @(negedge clk);
      n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin n_err++; $display("FAIL lu_fwd got %b exp 1010", {bus.fwd_a, bus.fwd_b}); end
      n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got %0d exp 1", bus.stall_cnt); end
      tick();
   endtask

   task automatic test_freeze_hazard();
      do_reset();
      drive(1, 1, 1, 0, 3'd1, 3'd4, 1, 3'd0, 0);
      tick();
      drive(1, 1, 0, 0, 3'd2, 3'd1, 1, 3'd1, 1);
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_bubble} !== 6'b000000) begin n_err++; $display("FAIL frz_cycle%0d got %b exp 000000", i, {bus.pc_en, bus.ifid_en, bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_bubble}); end
         tick();
      end
      bus.mem_busy = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.idex_bubble} !== 2'b01) begin n_err++; $display("FAIL frz_then_stall got %b exp 01", {bus.pc_en, bus.idex_bubble}); end
      tick();
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.idex_bubble} !== 2'b10) begin n_err++; $display("FAIL frz_one_stall got %b exp 10", {bus.pc_en, bus.idex_bubble}); end
      tick();
      idle();
      @(negedge clk);
      n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin n_err++; $display("FAIL frz_fwd got %b exp 1010", {bus.fwd_a, bus.fwd_b}); end
      n_cmp++; if (bus.stall_cnt !== 16'd4) begin n_err++; $display("FAIL frz_stall_cnt got %0d exp 4", bus.stall_cnt); end
      tick();
   endtask

   task automatic test_flush_halt();
      do_reset();
      drive(1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 0);   // HALT in ID
      bus.ex_br_taken = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus.ifid_flush, bus.idex_bubble, bus.pc_en} !== 3'b111) begin n_err++; $display("FAIL flush_sig got %b exp 111", {bus.ifid_flush, bus.idex_bubble, bus.pc_en}); end
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.pc_en, bus.halted} !== 2'b10) begin n_err++; $display("FAIL flush_stay_run%0d got %b exp 10", i, {bus.pc_en, bus.halted}); end
         tick();
      end
   endtask

   task automatic test_halt_drain();
      do_reset();
      drive(1, 1, 0, 0, 3'd1, 3'd2, 1, 3'd3, 1);   // ADD R1
      tick();
      drive(1, 1, 1, 0, 3'd2, 3'd4, 1, 3'd0, 0);   // LD R2
      tick();
      drive(1, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 0);   // HALT
      @(negedge clk);
      n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL halt_issue_pc got %b exp 1", bus.pc_en); end
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.halted} !== 4'b0010) begin n_err++; $display("FAIL drain_cycle%0d got %b exp 0010", i, {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.halted}); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.halted, bus.pc_en, bus.exmem_en, bus.memwb_en} !== 4'b1000) begin n_err++; $display("FAIL halted_%0d got %b exp 1000", i, {bus.halted, bus.pc_en, bus.exmem_en, bus.memwb_en}); end
         tick();
      end
   endtask

   task automatic test_reset_drain();
      do_reset();
      drive(1, 1, 1, 0, 3'd1, 3'd4, 1, 3'd0, 0);   // LD R1
      tick();
      drive(1, 1, 0, 0, 3'd2, 3'd1, 1, 3'd1, 1);   // ADD R2,R1,R1 (stalls once)
      tick();
      tick();
      drive(1, 0, 0, 1, 3'd0, 3'd2, 1, 3'd0, 0);   // HALT reading R2
      tick();
      idle();
      @(negedge clk);
      n_cmp++; if ({bus.fwd_a, bus.pc_en} !== 3'b010) begin n_err++; $display("FAIL rd_pre got %b exp 010", {bus.fwd_a, bus.pc_en}); end
      n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL rd_pre_cnt got %0d exp 1", bus.stall_cnt); end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.halted, bus.fwd_a, bus.fwd_b} !== 5'b00000 || bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL rd_async got %b/%0d exp 00000/0", {bus.halted, bus.fwd_a, bus.fwd_b}, bus.stall_cnt); end
      n_cmp++; if ({bus.pc_en, bus.ifid_flush, bus.idex_bubble} !== 3'b011) begin n_err++; $display("FAIL rd_async_en got %b exp 011", {bus.pc_en, bus.ifid_flush, bus.idex_bubble}); end
      #1;
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.halted} !== 4'b1100) begin n_err++; $display("FAIL rd_resume got %b exp 1100", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.halted}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_fwd_exmem();
      test_load_use();
      test_freeze_hazard();
      test_flush_halt();
      test_halt_drain();
      test_reset_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
